// File: rtl/stats_reporter_if.sv
// Signal bundle between the stats block side and the status reporter.
// The reporter is the slave: it consumes the request and stats, drives the UART side.
interface stats_reporter_if;
    logic       start;
    logic [4:0] hunger;
    logic [4:0] happiness;
    logic [4:0] health;
    logic [4:0] hygiene;
    logic [4:0] energy;
    logic       is_sleeping;
    logic       tx;
    logic       busy;
    logic       done;

    modport master (
        output start, hunger, happiness, health, hygiene, energy, is_sleeping,
        input  tx, busy, done
    );

    modport slave (
        input  start, hunger, happiness, health, hygiene, energy, is_sleeping,
        output tx, busy, done
    );
endinterface

// File: rtl/stats_reporter.sv
// Snapshots the pet stats on request and sends them as a 24-byte ASCII status
// line ("eHH pHH dHH bHH nHH zS\r\n") over 8N1 UART.
module stats_reporter #(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic              clk,
    input  logic              reset,
    stats_reporter_if.slave   bus
);
    localparam int              CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [4:0]      LAST_BYTE = 5'd23;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [4:0]       byte_idx_q, byte_idx_d;
    logic [9:0]       shift_q, shift_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [4:0]       hunger_q, hunger_d, happiness_q, happiness_d, health_q, health_d;
    logic [4:0]       hygiene_q, hygiene_d, energy_q, energy_d;
    logic             sleep_q, sleep_d;

    logic             bit_end;
    logic [4:0]       load_idx;
    logic [7:0]       load_byte;

    // ASCII tens or units digit of a 0..31 value.
    function automatic logic [7:0] dec_char(input logic [4:0] v, input logic units);
        logic [1:0] tens;
        logic [3:0] unit;
        tens = (v >= 5'd30) ? 2'd3 : (v >= 5'd20) ? 2'd2 : (v >= 5'd10) ? 2'd1 : 2'd0;
        unit = 4'(v - 5'(tens) * 5'd10);
        return units ? {4'h3, unit} : {6'b0011_00, tens};
    endfunction

    // Byte to load next: byte 0 when accepting, otherwise the one after the current.
    always_comb begin
        load_idx = (state_q == S_IDLE) ? 5'd0 : byte_idx_q + 5'd1;
        case (load_idx)
            5'd0:    load_byte = 8'h65;
            5'd1:    load_byte = dec_char(hunger_q, 1'b0);
            5'd2:    load_byte = dec_char(hunger_q, 1'b1);
            5'd4:    load_byte = 8'h70;
            5'd5:    load_byte = dec_char(happiness_q, 1'b0);
            5'd6:    load_byte = dec_char(happiness_q, 1'b1);
            5'd8:    load_byte = 8'h64;
            5'd9:    load_byte = dec_char(health_q, 1'b0);
            5'd10:   load_byte = dec_char(health_q, 1'b1);
            5'd12:   load_byte = 8'h62;
            5'd13:   load_byte = dec_char(hygiene_q, 1'b0);
            5'd14:   load_byte = dec_char(hygiene_q, 1'b1);
            5'd16:   load_byte = 8'h6E;
            5'd17:   load_byte = dec_char(energy_q, 1'b0);
            5'd18:   load_byte = dec_char(energy_q, 1'b1);
            5'd20:   load_byte = 8'h7A;
            5'd21:   load_byte = sleep_q ? 8'h31 : 8'h30;
            5'd22:   load_byte = 8'h0D;
            5'd23:   load_byte = 8'h0A;
            default: load_byte = 8'h20;
        endcase
    end

    assign bit_end = (bit_cnt_q == CNT_LAST);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        bit_idx_d   = bit_idx_q;
        byte_idx_d  = byte_idx_q;
        shift_d     = shift_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        hunger_d    = hunger_q;
        happiness_d = happiness_q;
        health_d    = health_q;
        hygiene_d   = hygiene_q;
        energy_d    = energy_q;
        sleep_d     = sleep_q;

        if (state_q != S_IDLE) begin
            bit_cnt_d = bit_end ? '0 : bit_cnt_q + 1'b1;
        end

        // The shift register shifts in ones, so it holds all ones (tx idle) between frames.
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    hunger_d    = bus.hunger;
                    happiness_d = bus.happiness;
                    health_d    = bus.health;
                    hygiene_d   = bus.hygiene;
                    energy_d    = bus.energy;
                    sleep_d     = bus.is_sleeping;
                    bit_cnt_d   = '0;
                    byte_idx_d  = 5'd0;
                    shift_d     = {1'b1, load_byte, 1'b0};
                    busy_d      = 1'b1;
                    state_d     = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    shift_d   = {1'b1, shift_q[9:1]};
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d   = {1'b1, shift_q[9:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (byte_idx_q < LAST_BYTE) begin
                        byte_idx_d = byte_idx_q + 5'd1;
                        shift_d    = {1'b1, load_byte, 1'b0};
                        state_d    = S_START;
                    end else begin
                        byte_idx_d = 5'd0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            bit_idx_q   <= 3'd0;
            byte_idx_q  <= 5'd0;
            shift_q     <= '1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            hunger_q    <= 5'd0;
            happiness_q <= 5'd0;
            health_q    <= 5'd0;
            hygiene_q   <= 5'd0;
            energy_q    <= 5'd0;
            sleep_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            bit_idx_q   <= bit_idx_d;
            byte_idx_q  <= byte_idx_d;
            shift_q     <= shift_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            hunger_q    <= hunger_d;
            happiness_q <= happiness_d;
            health_q    <= health_d;
            hygiene_q   <= hygiene_d;
            energy_q    <= energy_d;
            sleep_q     <= sleep_d;
        end
    end

    assign bus.tx   = shift_q[0];
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_stats_reporter.sv
// Bench for stats_reporter: a fast instance (4 clocks/bit) for frame content and
// handshake behaviour, and a default-rate instance (234 clocks/bit) for bit timing.
module tb_stats_reporter;
    localparam int CPB_F = 4;
    localparam int CPB_S = 234;

    logic clk   = 1'b0;
    logic rst_f = 1'b1;
    logic rst_s = 1'b1;

    int checks = 0;
    int errors = 0;

    logic [7:0] rx_q[$];
    int         fe_cnt = 0;
    int         last_base = 0;

    stats_reporter_if bus_f ();
    stats_reporter_if bus_s ();

    stats_reporter #(.CLKS_PER_BIT(CPB_F)) u_fast (.clk(clk), .reset(rst_f), .bus(bus_f));
    stats_reporter #(.CLKS_PER_BIT(CPB_S)) u_slow (.clk(clk), .reset(rst_s), .bus(bus_s));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference line straight from the field/decimal rules.
    function automatic string expect_line(input int h, p, d, b, n, input int s);
        return $sformatf("e%02d p%02d d%02d b%02d n%02d z%0d\r\n", h, p, d, b, n, s);
    endfunction

    // UART receiver on the fast instance: mid-bit sampling, LSB first.
    initial begin : decoder
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (bus_f.tx === 1'b0) begin
                repeat (CPB_F / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB_F) @(negedge clk);
                    b[i] = bus_f.tx;
                end
                repeat (CPB_F) @(negedge clk);
                if (bus_f.tx !== 1'b1) fe_cnt++;
                rx_q.push_back(b);
            end
        end
    end

    // mode: 0 plain, 1 zero inputs after acceptance, 2 extra starts while busy, 3 reset at E+500
    task automatic run_frame(input int h, p, d, b, n, s, input int mode);
        string line;
        int    base, fe0, busy_n, done_n, done_at;
        logic [31:0] got;
        line = expect_line(h, p, d, b, n, s);
        bus_f.hunger      = 5'(h);
        bus_f.happiness   = 5'(p);
        bus_f.health      = 5'(d);
        bus_f.hygiene     = 5'(b);
        bus_f.energy      = 5'(n);
        bus_f.is_sleeping = 1'(s);
        base      = rx_q.size();
        last_base = base;
        fe0       = fe_cnt;
        @(negedge clk);
        bus_f.start = 1'b1;
        @(negedge clk);
        bus_f.start = 1'b0;
        check("accept_busy", bus_f.busy, 1);
        check("accept_tx", bus_f.tx, 0);
        if (mode == 1) begin
            bus_f.hunger = 0; bus_f.happiness = 0; bus_f.health = 0;
            bus_f.hygiene = 0; bus_f.energy = 0; bus_f.is_sleeping = 0;
        end
        busy_n  = 1;
        done_n  = 0;
        done_at = -1;
        for (int k = 1; k <= 1000; k++) begin
            @(negedge clk);
            if (mode == 2) bus_f.start = (k == 99 || k == 959);
            if (mode == 3 && k == 500) begin
                #1 rst_f = 1'b1;
                #1;
                check("abort_tx", bus_f.tx, 1);
                check("abort_busy", bus_f.busy, 0);
                repeat (3) @(posedge clk);
                @(negedge clk);
                rst_f = 1'b0;
                return;
            end
            if (bus_f.busy === 1'b1) busy_n++;
            if (bus_f.done === 1'b1) begin
                done_n++;
                done_at = k;
            end
        end
        check("busy_cycles", busy_n, 960);
        check("done_count", done_n, 1);
        check("done_cycle", done_at, 960);
        check("byte_count", rx_q.size() - base, 24);
        check("framing", fe_cnt - fe0, 0);
        for (int i = 0; i < 24; i++) begin
            got = (base + i < rx_q.size()) ? 32'(rx_q[base + i]) : 32'hDEAD;
            check($sformatf("byte%0d", i), got, 32'(line[i]));
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        string      line_s;
        logic [9:0] lvl;
        int         mism[10];
        int         low_n;
        int         v[5];

        bus_f.start = 0; bus_f.hunger = 0; bus_f.happiness = 0; bus_f.health = 0;
        bus_f.hygiene = 0; bus_f.energy = 0; bus_f.is_sleeping = 0;
        bus_s.start = 0; bus_s.hunger = 0; bus_s.happiness = 0; bus_s.health = 0;
        bus_s.hygiene = 0; bus_s.energy = 0; bus_s.is_sleeping = 0;

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hold_tx", bus_f.tx, 1);
        rst_f = 1'b0;
        rst_s = 1'b0;
        @(negedge clk);
        check("rst_tx", bus_f.tx, 1);
        check("rst_busy", bus_f.busy, 0);
        check("rst_done", bus_f.done, 0);
        check("rst_s_tx", bus_s.tx, 1);
        check("rst_s_busy", bus_s.busy, 0);
        check("rst_s_done", bus_s.done, 0);
        low_n = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (bus_f.tx !== 1'b1 || bus_f.busy !== 1'b0) low_n++;
        end
        check("idle_1000", low_n, 0);

        // Basic frame with snapshot: inputs zeroed right after acceptance
        run_frame(5, 12, 0, 31, 15, 1, 1);
        check("b0_e", 32'(rx_q[last_base + 0]), 32'h65);
        check("b2_h0", 32'(rx_q[last_base + 2]), 32'h35);
        check("b14_b0", 32'(rx_q[last_base + 14]), 32'h31);
        check("b22_cr", 32'(rx_q[last_base + 22]), 32'h0D);

        // Zero frame with starts at E+100 and on the done edge rejected
        run_frame(0, 0, 0, 0, 0, 0, 2);
        check("after_reject_busy", bus_f.busy, 0);

        // Decimal boundaries
        run_frame(9, 10, 19, 20, 29, 0, 0);
        run_frame(30, 31, 1, 11, 21, 1, 0);

        // Reset mid-frame, then a full frame
        run_frame(7, 8, 9, 10, 11, 1, 3);
        repeat (60) @(negedge clk);
        check("post_abort_tx", bus_f.tx, 1);
        run_frame(17, 3, 26, 14, 30, 0, 0);

        // Random frames
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 5; i++) v[i] = int'($urandom_range(0, 31));
            run_frame(v[0], v[1], v[2], v[3], v[4], int'($urandom_range(0, 1)), 0);
        end

        // Bit timing at 234 clocks per bit on byte 0
        bus_s.hunger = 5; bus_s.happiness = 12; bus_s.health = 0;
        bus_s.hygiene = 31; bus_s.energy = 15; bus_s.is_sleeping = 1;
        line_s = expect_line(5, 12, 0, 31, 15, 1);
        lvl = {1'b1, line_s[0], 1'b0};
        for (int k = 0; k < 10; k++) mism[k] = 0;
        @(negedge clk);
        bus_s.start = 1'b1;
        @(negedge clk);
        bus_s.start = 1'b0;
        for (int c = 0; c < 10 * CPB_S; c++) begin
            if (bus_s.tx !== lvl[c / CPB_S]) mism[c / CPB_S]++;
            @(negedge clk);
        end
        check("slow_next_start", bus_s.tx, 0);
        check("slow_busy", bus_s.busy, 1);
        for (int k = 0; k < 10; k++) check($sformatf("slow_bit%0d", k), mism[k], 0);
        #1 rst_s = 1'b1;
        #1;
        check("slow_abort_tx", bus_s.tx, 1);
        check("slow_abort_busy", bus_s.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
